// File: rtl/sc_multiplier_shiftadd_if.sv
// ============================================================================
// Module   : sc_multiplier_shiftadd_if
// Brief    : Start/done handshake and operand/product bus of the shift-add
//            multiplier; master = initiator, slave = multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sc_multiplier_shiftadd_if #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8
);
    logic                       SC_MULTIPLIER_start_InHigh;
    logic [WIDTH_A-1:0]         SC_MULTIPLIER_dataA_InBUS;
    logic [WIDTH_B-1:0]         SC_MULTIPLIER_dataB_InBUS;
    logic [WIDTH_A+WIDTH_B-1:0] SC_MULTIPLIER_product_OutBUS;
    logic                       SC_MULTIPLIER_done_OutHigh;
    logic                       SC_MULTIPLIER_busy_OutHigh;

    modport master (
        output SC_MULTIPLIER_start_InHigh,
        output SC_MULTIPLIER_dataA_InBUS,
        output SC_MULTIPLIER_dataB_InBUS,
        input  SC_MULTIPLIER_product_OutBUS,
        input  SC_MULTIPLIER_done_OutHigh,
        input  SC_MULTIPLIER_busy_OutHigh
    );

    modport slave (
        input  SC_MULTIPLIER_start_InHigh,
        input  SC_MULTIPLIER_dataA_InBUS,
        input  SC_MULTIPLIER_dataB_InBUS,
        output SC_MULTIPLIER_product_OutBUS,
        output SC_MULTIPLIER_done_OutHigh,
        output SC_MULTIPLIER_busy_OutHigh
    );
endinterface

`default_nettype wire

// File: rtl/sc_multiplier_shiftadd.sv
// ============================================================================
// Module   : sc_multiplier_shiftadd
// Brief    : Sequential unsigned shift-add multiplier, start/done responder.
//            Optional macro SC_MULTIPLIER_EARLYEXIT_EN ends RUN once the
//            remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_multiplier_shiftadd #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8
) (
    input  wire logic                  SC_MULTIPLIER_CLOCK_50,
    input  wire logic                  SC_MULTIPLIER_RESET_InLow,
    sc_multiplier_shiftadd_if.slave    bus
);

    localparam int PROD_W = WIDTH_A + WIDTH_B;
    localparam int CNT_W  = $clog2(WIDTH_B + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [PROD_W-1:0]   mcand, mcand_nxt;
    logic [WIDTH_B-1:0]  mplier, mplier_nxt;
    logic [PROD_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [PROD_W-1:0]   product, product_nxt;
    logic                done, done_nxt;
    logic                busy, busy_nxt;
    logic [PROD_W-1:0]   sum;
    logic                run_last;

    always_ff @(posedge SC_MULTIPLIER_CLOCK_50 or negedge SC_MULTIPLIER_RESET_InLow) begin
        if (!SC_MULTIPLIER_RESET_InLow) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            product <= product_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        product_nxt = product;
        sum         = mplier[0] ? (acc + mcand) : acc;
        run_last    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.SC_MULTIPLIER_start_InHigh) begin
                    mcand_nxt  = {{WIDTH_B{1'b0}}, bus.SC_MULTIPLIER_dataA_InBUS};
                    mplier_nxt = bus.SC_MULTIPLIER_dataB_InBUS;
                    acc_nxt    = '0;
                    cnt_nxt    = CNT_W'(WIDTH_B);
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                acc_nxt    = sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt - CNT_W'(1);
`ifdef SC_MULTIPLIER_EARLYEXIT_EN
                run_last   = (cnt_nxt == '0) || (mplier_nxt == '0);
`else
                run_last   = (cnt_nxt == '0);
`endif
                // Product captures the final sum on the RUN->DONE edge so it
                // is already valid in the cycle done is high.
                if (run_last) begin
                    state_nxt   = DONE;
                    product_nxt = sum;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt == RUN) || (state_nxt == DONE);
    end

    assign bus.SC_MULTIPLIER_product_OutBUS = product;
    assign bus.SC_MULTIPLIER_done_OutHigh   = done;
    assign bus.SC_MULTIPLIER_busy_OutHigh   = busy;

endmodule

`default_nettype wire

// File: tb/tb_sc_multiplier_shiftadd.sv
// ============================================================================
// Module   : tb_sc_multiplier_shiftadd
// Brief    : Scoreboard bench for sc_multiplier_shiftadd (reference = A*B).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_multiplier_shiftadd;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int PW = WA + WB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sc_multiplier_shiftadd_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus ();

    sc_multiplier_shiftadd #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .SC_MULTIPLIER_CLOCK_50    (clk),
        .SC_MULTIPLIER_RESET_InLow (rst_n),
        .bus                       (bus)
    );

    typedef struct {
        int            issue;
        int            done_cyc;
        logic [PW-1:0] prod;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_done = -100;
    logic [PW-1:0] exp_product = '0;
    logic          prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Number of RUN cycles implied by the multiplier operand.
    function automatic int run_len(input logic [WB-1:0] b);
`ifdef SC_MULTIPLIER_EARLYEXIT_EN
        int top;
        top = 0;
        for (int i = 0; i < WB; i++)
            if (b[i]) top = i + 1;
        return (top == 0) ? 1 : top;
`else
        return WB;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; the model decides whether it is accepted.
    task automatic issue(input logic [WA-1:0] a, input logic [WB-1:0] b);
        exp_t e;
        bus.SC_MULTIPLIER_start_InHigh = 1'b1;
        bus.SC_MULTIPLIER_dataA_InBUS  = a;
        bus.SC_MULTIPLIER_dataB_InBUS  = b;
        if (rst_n && cyc > last_done) begin
            e.issue    = cyc;
            e.done_cyc = cyc + run_len(b) + 1;
            e.prod     = PW'(a) * PW'(b);
            sb.push_back(e);
            last_done  = e.done_cyc;
        end
        step();
        bus.SC_MULTIPLIER_start_InHigh = 1'b0;
        bus.SC_MULTIPLIER_dataA_InBUS  = WA'($urandom);
        bus.SC_MULTIPLIER_dataB_InBUS  = WB'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc <= last_done) step();
    endtask

    // Monitor: pops the scoreboard on done and checks busy/product each cycle.
    always @(negedge clk) begin
        logic busy_exp;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_done actual=none required=cycle %0d", sb[0].done_cyc);
                void'(sb.pop_front());
            end
            busy_exp = (sb.size() > 0) && (cyc > sb[0].issue);
            check("busy", 32'(bus.SC_MULTIPLIER_busy_OutHigh), 32'(busy_exp));
            if (bus.SC_MULTIPLIER_done_OutHigh) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    check("done_cycle", 32'(cyc), 32'(sb[0].done_cyc));
                    exp_product = sb[0].prod;
                    void'(sb.pop_front());
                end
            end
            check("product", 32'(bus.SC_MULTIPLIER_product_OutBUS), 32'(exp_product));
            check("done_width", 32'(bus.SC_MULTIPLIER_done_OutHigh && prev_done), 32'd0);
            prev_done = bus.SC_MULTIPLIER_done_OutHigh;
        end
    end

    initial begin
        bool_init();
        // Reset held with random inputs, including start pulses.
        for (int i = 0; i < 5; i++) begin
            bus.SC_MULTIPLIER_start_InHigh = 1'($urandom);
            bus.SC_MULTIPLIER_dataA_InBUS  = WA'($urandom);
            bus.SC_MULTIPLIER_dataB_InBUS  = WB'($urandom);
            step();
            check("rst_product", 32'(bus.SC_MULTIPLIER_product_OutBUS), 32'd0);
            check("rst_done",    32'(bus.SC_MULTIPLIER_done_OutHigh),   32'd0);
            check("rst_busy",    32'(bus.SC_MULTIPLIER_busy_OutHigh),   32'd0);
        end
        bus.SC_MULTIPLIER_start_InHigh = 1'b0;
        rst_n = 1'b1;
        repeat (20) step();

        issue(8'd13, 8'd11);
        wait_idle();
        repeat (3) step();

        issue(8'd255, 8'd255);
        wait_idle();
        issue(8'd0, 8'd200);
        wait_idle();
        issue(8'd1, 8'd128);
        wait_idle();

        // Second start in cycle 4 of a run must be ignored.
        issue(8'd13, 8'd11);
        repeat (3) step();
        issue(8'd7, 8'd7);
        wait_idle();
        step();

        // Reset in cycle 5 of a run discards it.
        issue(8'd99, 8'd77);
        repeat (4) step();
        rst_n = 1'b0;
        sb.delete();
        exp_product = '0;
        last_done   = -100;
        #1;
        check("midrun_rst_product", 32'(bus.SC_MULTIPLIER_product_OutBUS), 32'd0);
        check("midrun_rst_busy",    32'(bus.SC_MULTIPLIER_busy_OutHigh),   32'd0);
        step();
        rst_n = 1'b1;
        step();
        issue(8'd3, 8'd5);
        wait_idle();
        step();

        // Closed loop: restart exactly one cycle after each done.
        issue(WA'($urandom), WB'($urandom));
        for (int it = 0; it < 5; it++) begin
            int budget;
            budget = 0;
            while (!bus.SC_MULTIPLIER_done_OutHigh && budget < 40) begin
                step();
                budget++;
            end
            if (!bus.SC_MULTIPLIER_done_OutHigh) begin
                checks++;
                errors++;
                $display("FAIL loop_done_timeout actual=none required=done (iteration %0d)", it);
            end
            step();
            if (it < 4) issue(WA'($urandom), WB'($urandom));
        end
        wait_idle();

        issue(8'd9, 8'd3);
        wait_idle();
        issue(8'd77, 8'd0);
        wait_idle();
        issue(8'd5, 8'd128);
        wait_idle();

        // Random traffic, including starts while busy.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) issue(WA'($urandom), WB'($urandom));
            else step();
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) step();
        step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic bool_init();
        bus.SC_MULTIPLIER_start_InHigh = 1'b0;
        bus.SC_MULTIPLIER_dataA_InBUS  = '0;
        bus.SC_MULTIPLIER_dataB_InBUS  = '0;
    endtask

endmodule

`default_nettype wire
